// File: rtl/pipe_stage_skid_if.sv
// Valid/ready channel carrying one pipeline beat (control field + payload).
//   valid : producer offers a beat
//   ready : consumer can take the beat
//   ctrl  : control field of the beat (CTRL_W bits)
//   data  : payload of the beat (DATA_W bits)
// master drives valid/ctrl/data and reads ready; slave is the mirror.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 11
) ();
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and saturating stall counter.
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   in_if     : upstream channel (slave): valid/ctrl/data in, ready out
//   out_if    : downstream channel (master): valid/ctrl/data out, ready in
//   flush     : squash all held beats and the beat offered this cycle
//   stall_cnt : cycles with out valid and not ready, saturating
// in_if.ready and all out_if fields come straight from registers.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 11,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  pipe_stage_skid_if.slave         in_if,
  pipe_stage_skid_if.master        out_if,
  input  logic                     flush,
  output logic [CNT_W-1:0]         stall_cnt
);

  // State bits are {main_valid, skid_valid}; 01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic main_valid, skid_valid;
  logic main_valid_d, skid_valid_d;
  logic accept, drain;

  assign {main_valid, skid_valid} = state_q;

  assign accept = in_if.valid & in_ready_q;
  assign drain  = main_valid & out_if.ready;

  always_comb begin
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Payload register keeps its value; only the control field is cleared.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_ctrl_d = in_if.ctrl;
          skid_data_d = in_if.data;
        end
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_if.ctrl;
        main_data_d  = in_if.data;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_if.ctrl;
      skid_data_d  = in_if.data;
    end

    state_d = state_e'({main_valid_d, skid_valid_d});

    // Registering the next skid state keeps out_ready off the in_ready path
    // while still blocking input on the very cycle the skid entry is full.
    in_ready_d = ~skid_valid_d;

    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_if.ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_if.valid = main_valid;
  assign out_if.ctrl  = main_ctrl_q;
  assign out_if.data  = main_data_q;
  assign in_if.ready  = in_ready_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 11;
  localparam int unsigned NW = 4;

  typedef logic [CW+DW-1:0] beat_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [NW-1:0] stall_cnt;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) in_if ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) out_if ();

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_if    (in_if),
    .out_if   (out_if),
    .flush    (flush),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned spurious = 0;

  beat_t model_q[$];  // beats the stage should currently hold, oldest first
  beat_t exp_q[$];    // expected beat for each observed delivery
  beat_t obs_q[$];    // beats seen leaving the stage

  // Advance one clock; record handshakes sampled before the edge.
  task automatic tick();
    logic acc, drn, fl, rs;
    beat_t ib, ob;
    @(negedge clk);
    acc = (in_if.valid === 1'b1) && (in_if.ready === 1'b1);
    drn = (out_if.valid === 1'b1) && (out_if.ready === 1'b1);
    fl  = flush;
    rs  = rst;
    ib  = {in_if.ctrl, in_if.data};
    ob  = {out_if.ctrl, out_if.data};
    @(posedge clk);
    #1;
    if (drn) begin
      obs_q.push_back(ob);
      if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
      else spurious++;
    end
    if (rs || fl) model_q.delete();
    else if (acc) model_q.push_back(ib);
  endtask

  task automatic idle(input int unsigned n);
    in_if.valid = 1'b0;
    out_if.ready = 1'b1;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_if.valid = 1'b1;
    in_if.ctrl  = c;
    in_if.data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    out_if.ready = 1'b0;
    offer(11'h7FF, 64'h5555);
    for (int unsigned i = 0; i < 4; i++) begin
      if (i == 2) begin
        rst = 1'b0;
        in_if.valid = 1'b0;
      end
      tick();
      checks++;
      if (out_if.valid !== 1'b0 || out_if.ctrl !== '0 || out_if.data !== '0 ||
          in_if.ready !== 1'b1 || stall_cnt !== '0) begin
        errors++;
        $display("FAIL reset[%0d]: got v=%b c=%h d=%h rdy=%b cnt=%0d, expected v=0 c=0 d=0 rdy=1 cnt=0",
                 i, out_if.valid, out_if.ctrl, out_if.data, in_if.ready, stall_cnt);
      end
    end
    model_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_streaming();
    beat_t ob, eb;
    logic [DW-1:0] d;
    out_if.ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      d = 64'h10 + 64'(i);
      offer(11'h100 + 11'(i), d);
      tick();
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== d || out_if.ctrl !== 11'h100 + 11'(i) ||
          in_if.ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_beat[%0d]: got v=%b c=%h d=%h rdy=%b, expected v=1 c=%h d=%h rdy=1",
                 i, out_if.valid, out_if.ctrl, out_if.data, in_if.ready, 11'h100 + 11'(i), d);
      end
    end
    in_if.valid = 1'b0;
    tick();
    checks++;
    if (out_if.valid !== 1'b0 || out_if.ctrl !== '0) begin
      errors++;
      $display("FAIL stream_end: got v=%b c=%h, expected v=0 c=0", out_if.valid, out_if.ctrl);
    end
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL stream_count: got %0d beats, expected 8", obs_q.size());
    end
    for (int unsigned i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      ob = obs_q.pop_front();
      eb = exp_q.pop_front();
      checks++;
      if (ob[DW-1:0] !== 64'h10 + 64'(i) || ob !== eb) begin
        errors++;
        $display("FAIL stream_order[%0d]: got %h, expected %h (data %h)", i, ob, eb, 64'h10 + 64'(i));
      end
    end
  endtask

  task automatic test_skid();
    beat_t ob, eb;
    logic [DW-1:0] seq [3];
    seq[0] = 64'hA0; seq[1] = 64'hA1; seq[2] = 64'hA2;
    out_if.ready = 1'b0;
    offer(11'h0A0, 64'hA0);
    tick();
    checks++;
    if (out_if.valid !== 1'b1 || out_if.data !== 64'hA0 || in_if.ready !== 1'b1 || stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL skid_first: got v=%b d=%h rdy=%b cnt=%0d, expected v=1 d=a0 rdy=1 cnt=0",
               out_if.valid, out_if.data, in_if.ready, stall_cnt);
    end
    offer(11'h0A1, 64'hA1);
    tick();
    checks++;
    if (out_if.data !== 64'hA0 || in_if.ready !== 1'b0 || stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL skid_catch: got d=%h rdy=%b cnt=%0d, expected d=a0 rdy=0 cnt=1",
               out_if.data, in_if.ready, stall_cnt);
    end
    offer(11'h0A2, 64'hA2);
    for (int unsigned i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_if.data !== 64'hA0 || in_if.ready !== 1'b0 || stall_cnt !== 4'(2 + i)) begin
        errors++;
        $display("FAIL skid_hold[%0d]: got d=%h rdy=%b cnt=%0d, expected d=a0 rdy=0 cnt=%0d",
                 i, out_if.data, in_if.ready, stall_cnt, 2 + i);
      end
    end
    out_if.ready = 1'b1;
    tick();
    checks++;
    if (out_if.valid !== 1'b1 || out_if.data !== 64'hA1 || in_if.ready !== 1'b1 || stall_cnt !== 4'd3) begin
      errors++;
      $display("FAIL skid_release: got v=%b d=%h rdy=%b cnt=%0d, expected v=1 d=a1 rdy=1 cnt=3",
               out_if.valid, out_if.data, in_if.ready, stall_cnt);
    end
    tick();
    in_if.valid = 1'b0;
    tick();
    tick();
    checks++;
    if (obs_q.size() != 3 || model_q.size() != 0) begin
      errors++;
      $display("FAIL skid_count: got %0d delivered %0d held, expected 3 delivered 0 held",
               obs_q.size(), model_q.size());
    end
    for (int unsigned i = 0; i < 3 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      ob = obs_q.pop_front();
      eb = exp_q.pop_front();
      checks++;
      if (ob[DW-1:0] !== seq[i] || ob !== eb) begin
        errors++;
        $display("FAIL skid_order[%0d]: got %h, expected %h (data %h)", i, ob, eb, seq[i]);
      end
    end
  endtask

  task automatic test_flush();
    beat_t ob, eb;
    out_if.ready = 1'b0;
    offer(11'h0B0, 64'hB0);
    tick();
    offer(11'h0B1, 64'hB1);
    tick();
    flush = 1'b1;
    offer(11'h0B2, 64'hB2);
    tick();
    flush = 1'b0;
    checks++;
    if (out_if.valid !== 1'b0 || out_if.ctrl !== '0 || in_if.ready !== 1'b1 ||
        out_if.data !== 64'hB0 || stall_cnt !== 4'd5) begin
      errors++;
      $display("FAIL flush_full: got v=%b c=%h rdy=%b d=%h cnt=%0d, expected v=0 c=0 rdy=1 d=b0 cnt=5",
               out_if.valid, out_if.ctrl, in_if.ready, out_if.data, stall_cnt);
    end
    idle(3);
    checks++;
    if (obs_q.size() != 0 || out_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_leak: got %0d beats delivered v=%b, expected 0 delivered v=0",
               obs_q.size(), out_if.valid);
    end
    // Beat accepted in the flush cycle must be dropped too.
    out_if.ready = 1'b0;
    offer(11'h0C0, 64'hC0);
    tick();
    flush = 1'b1;
    offer(11'h0C1, 64'hC1);
    tick();
    flush = 1'b0;
    idle(3);
    checks++;
    if (obs_q.size() != 0 || out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_accept: got %0d beats delivered v=%b rdy=%b, expected 0 v=0 rdy=1",
               obs_q.size(), out_if.valid, in_if.ready);
    end
    // A drain in the flush cycle is still delivered; the skid beat is not.
    out_if.ready = 1'b0;
    offer(11'h0D0, 64'hD0);
    tick();
    offer(11'h0D1, 64'hD1);
    tick();
    in_if.valid = 1'b0;
    out_if.ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle(3);
    checks++;
    if (obs_q.size() != 1 || model_q.size() != 0 || spurious != 0) begin
      errors++;
      $display("FAIL flush_drain_count: got %0d delivered %0d spurious, expected 1 delivered 0 spurious",
               obs_q.size(), spurious);
    end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      ob = obs_q.pop_front();
      eb = exp_q.pop_front();
      checks++;
      if (ob[DW-1:0] !== 64'hD0 || ob !== eb) begin
        errors++;
        $display("FAIL flush_drain: got %h, expected %h (data d0)", ob, eb);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_if.ready = 1'b0;
    offer(11'h0E0, 64'hE0);
    tick();
    in_if.valid = 1'b0;
    for (int unsigned i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (stall_cnt !== 4'((i > 15) ? 15 : i) || out_if.valid !== 1'b1) begin
        errors++;
        $display("FAIL sat_count[%0d]: got cnt=%0d v=%b, expected cnt=%0d v=1",
                 i, stall_cnt, out_if.valid, (i > 15) ? 15 : i);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (stall_cnt !== 4'd0 || out_if.valid !== 1'b0 || out_if.ctrl !== '0 || in_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL sat_reset: got cnt=%0d v=%b c=%h rdy=%b, expected cnt=0 v=0 c=0 rdy=1",
               stall_cnt, out_if.valid, out_if.ctrl, in_if.ready);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_simultaneous();
    beat_t ob, eb;
    logic [DW-1:0] seq [3];
    seq[0] = 64'hF0; seq[1] = 64'hF1; seq[2] = 64'hF2;
    out_if.ready = 1'b1;
    offer(11'h0F0, 64'hF0);
    tick();
    for (int unsigned i = 1; i < 3; i++) begin
      offer(11'h0F0 + 11'(i), seq[i]);
      tick();
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== seq[i] || in_if.ready !== 1'b1) begin
        errors++;
        $display("FAIL simul[%0d]: got v=%b d=%h rdy=%b, expected v=1 d=%h rdy=1",
                 i, out_if.valid, out_if.data, in_if.ready, seq[i]);
      end
    end
    in_if.valid = 1'b0;
    out_if.ready = 1'b0;
    tick();
    checks++;
    if (in_if.ready !== 1'b1 || out_if.data !== 64'hF2) begin
      errors++;
      $display("FAIL simul_skid_unused: got rdy=%b d=%h, expected rdy=1 d=f2", in_if.ready, out_if.data);
    end
    idle(2);
    checks++;
    if (obs_q.size() != 3 || model_q.size() != 0) begin
      errors++;
      $display("FAIL simul_count: got %0d delivered %0d held, expected 3 and 0", obs_q.size(), model_q.size());
    end
    for (int unsigned i = 0; i < 3 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      ob = obs_q.pop_front();
      eb = exp_q.pop_front();
      checks++;
      if (ob[DW-1:0] !== seq[i] || ob !== eb) begin
        errors++;
        $display("FAIL simul_order[%0d]: got %h, expected %h", i, ob, eb);
      end
    end
  endtask

  task automatic test_random();
    beat_t ob, eb;
    int unsigned n;
    for (int unsigned i = 0; i < 300; i++) begin
      offer(11'($urandom), {32'($urandom), 32'($urandom)});
      in_if.valid = 1'($urandom_range(0, 1));
      out_if.ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    idle(4);
    checks++;
    if (model_q.size() != 0 || spurious != 0 || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_drain: got %0d held %0d spurious %0d/%0d obs/exp, expected 0 held 0 spurious equal counts",
               model_q.size(), spurious, obs_q.size(), exp_q.size());
    end
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ob = obs_q.pop_front();
      eb = exp_q.pop_front();
      checks++;
      if (ob !== eb) begin
        errors++;
        $display("FAIL random_order[%0d]: got %h, expected %h", n, ob, eb);
      end
      n++;
    end
  endtask

  initial begin
    in_if.valid = 1'b0;
    in_if.ctrl = '0;
    in_if.data = '0;
    out_if.ready = 1'b0;
    flush = 1'b0;
    rst = 1'b1;
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_saturation();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units, expected completion");
    $fatal(1, "timeout");
  end

endmodule
